emu_dt_arbiter: RTL and testbench
=================================

// Module: emu_dt_arbiter
// PURPOSE
//  Timestep arbiter feeding the emulator interface dt/clk domain. Collects per-block dt requests
//  (signed fixed-point, 27-bit significand, exponent -46, ~0.014 ps/LSB) from the analog models,
//  reduces them to the minimum, and issues the granted dt that every model consumes next step.
//  Also keeps the accumulated emulated time. Sits directly upstream of every emu.dt consumer.
// PARAMETERS
//  N_REQ      4         number of dt requesters (1..16)
//  TIME_WIDTH 64        width of emulated-time accumulator, same LSB as dt
//  DT_DEFAULT 27'd70369 dt granted when no request is valid (~1 ns)
// PORTS
//  clk        in   1                   emulator clock
//  rst_n      in   1                   asynchronous, active-low reset
//  req_dt     in   N_REQ*DT_WIDTH      packed signed dt requests; requester i at [i*DT_WIDTH +: DT_WIDTH]
//  req_vld    in   N_REQ               request i participates in current reduction
//  stall      in   1                   hold time: grant dt=0, no accumulation
//  dt         out  DT_WIDTH            granted signed dt (drives emu dt)
//  dt_vld     out  1                   dt is a fresh grant this cycle
//  emu_time   out  TIME_WIDTH          unsigned sum of all granted dt
//  neg_err    out  1                   sticky: a valid negative request was seen
//  time_limit in   TIME_WIDTH          [TIME_LIMIT_EN only] stop time
//  done       out  1                   [TIME_LIMIT_EN only] limit reached
// BEHAVIOUR
//  Reset (rst_n=0, async): dt=0, dt_vld=0, emu_time=0, neg_err=0, done=0, FSM=INIT, pipeline regs cleared.
//  Async assertion, synchronous deassertion via a 2-flop synchronizer on rst_n.
//  FSM: INIT -> RUN on first clk after reset release (1 cycle, pipeline flush).
//   RUN -> HOLD when stall=1. HOLD -> RUN when stall=0. RUN -> DONE (TIME_LIMIT_EN only).
//  DONE is terminal until reset.
//  Reduction: stage 1 masks invalid requests to DT_MAX, clamps negatives to 0 and sets neg_err.
//   Stage 2 computes the pairwise min tree, registered.
//   If all req_vld=0, result=DT_DEFAULT.
//   Latency: req inputs at cycle n -> dt at cycle n+2. Fully pipelined, one grant per cycle.
//  Ties: equal minima give the identical value; no index is exported.
//  dt_vld=1 on every RUN cycle after the pipeline has filled (2 cycles after INIT); 0 in INIT/DONE.
//  HOLD: dt=0, dt_vld=1 (zero step granted), emu_time unchanged.
//   In-flight pipeline results are discarded, not queued.
//   Stall is sampled at the output stage, so dt goes to 0 in the cycle after stall rises.
//  Accumulator: emu_time <= emu_time + zero-extended dt each cycle dt_vld=1.
//   Saturates at all-ones, no wrap.
//  DT_MAX = 2^(DT_WIDTH-1)-1 (~0.95 us). A zero request grants dt=0 legally.
// CONFIGURATION
//  Macro EMU_DT_TIME_LIMIT_EN.
//  Defined: adds time_limit/done. The granted dt is clipped to (time_limit - emu_time) when smaller.
//   When emu_time == time_limit, FSM enters DONE: dt=0, dt_vld=0, done=1.
//  Undefined: the ports are absent, there is no clipping, and DONE is unreachable.
// STRUCTURE
//  Package emu_dt_pkg holds:
//   - DT_WIDTH=27, DT_EXPONENT=-46, DT_MAX constants
//   - typedef dt_t (logic signed [DT_WIDTH-1:0])
//   - FSM state enum (INIT, RUN, HOLD, DONE)
//  Sub-module dt_min_tree (N inputs, one register stage) implements the masked min reduction.
//  The top level holds the FSM, the clamp/mask stage and the accumulator.
// TESTING
//  1 Reset: drive rst_n=0 mid-run with emu_time=5000 -> all outputs 0 immediately (async), INIT after release.
//  2 Min: req_dt={70369,35184,140737,7037}, all valid -> dt=7037 two cycles later; emu_time +=7037 per cycle.
//  3 Mask/default: req_vld=4'b0000 -> dt=70369.
//    Then req_vld=4'b0100 with req2=35184 -> dt=35184.
//  4 Negative: req1=-10 valid, others 70369 -> dt=0, neg_err=1 and it stays 1 after req1 changes to 100.
//  5 Stall: stall high for 3 cycles during dt=7037 stream -> three dt=0 grants, emu_time flat.
//    Resumes at 7037 the cycle after stall falls.
//  6 EMU_DT_TIME_LIMIT_EN: time_limit=100000, constant req 70369 -> grants 70369 then 29631.
//    done=1 with emu_time=100000 exactly, dt_vld=0 thereafter.
//  Saturation: preload via TIME_WIDTH=28 build, DT_MAX requests -> emu_time holds 2^28-1.

Source files
------------

// File: rtl/emu_dt_pkg.sv
// Shared types and constants for the emulator timestep arbiter.
// dt is a signed fixed-point value with a 2^-46 s LSB (~0.014 ps).
package emu_dt_pkg;

    localparam int DT_WIDTH    = 27;
    localparam int DT_EXPONENT = -46;

    typedef logic signed [DT_WIDTH-1:0] dt_t;

    localparam dt_t DT_MAX = {1'b0, {(DT_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/dt_min_tree.sv
// Registered minimum over N non-negative dt values.
// Requester lanes are combined by a pairwise comparison tree.
module dt_min_tree
    import emu_dt_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N*DT_WIDTH-1:0] dt_i,
    output dt_t                   min_o
);

    localparam int NP = 1 << $clog2(N);

    dt_t min_d;
    dt_t min_q;

    // Unused leaves are padded with DT_MAX so they never win a comparison.
    function automatic dt_t treeMin(input logic [N*DT_WIDTH-1:0] v);
        dt_t node [2*NP];
        for (int i = 0; i < 2*NP; i++) node[i] = DT_MAX;
        for (int i = 0; i < N; i++) node[NP+i] = dt_t'(v[i*DT_WIDTH +: DT_WIDTH]);
        for (int i = NP-1; i >= 1; i--)
            node[i] = (node[2*i+1] < node[2*i]) ? node[2*i+1] : node[2*i];
        return node[1];
    endfunction

    always_comb min_d = treeMin(dt_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) min_q <= '0;
        else         min_q <= min_d;
    end

    assign min_o = min_q;

endmodule

// File: rtl/emu_dt_arbiter.sv
// Timestep arbiter: reduces per-block dt requests to the minimum, grants it and accumulates time.
// Optional stop-time feature (time_limit/done, dt clipping) enabled by macro EMU_DT_TIME_LIMIT_EN.
module emu_dt_arbiter
    import emu_dt_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  TIME_WIDTH = 64,
    parameter dt_t DT_DEFAULT = 27'd70369
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ*DT_WIDTH-1:0] req_dt,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic                      stall,
`ifdef EMU_DT_TIME_LIMIT_EN
    input  logic [TIME_WIDTH-1:0]     time_limit,
    output logic                      done,
`endif
    output logic [DT_WIDTH-1:0]       dt,
    output logic                      dt_vld,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      neg_err
);

    localparam int LANES = N_REQ + 1;

    logic [1:0]                  rstSync_q;
    logic                        rstInt_n;
    logic [LANES*DT_WIDTH-1:0]   masked;
    logic                        anyNeg;
    dt_t                         treeMin;
    dt_t                         grant;
    logic                        atLimit;
    logic [TIME_WIDTH:0]         sum;
    logic [TIME_WIDTH-1:0]       emuNext;
    state_e                      state_q;
    dt_t                         dt_q;
    logic                        dtVld_q;
    logic [TIME_WIDTH-1:0]       emuTime_q;
    logic                        negErr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstSync_q <= '0;
        else        rstSync_q <= {rstSync_q[0], 1'b1};
    end

    assign rstInt_n = rstSync_q[1];

    // The extra lane carries the default dt, which only wins when nobody requests.
    always_comb begin
        masked = '0;
        anyNeg = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!req_vld[i]) begin
                masked[i*DT_WIDTH +: DT_WIDTH] = DT_MAX;
            end else if (req_dt[i*DT_WIDTH + DT_WIDTH - 1]) begin
                masked[i*DT_WIDTH +: DT_WIDTH] = '0;
                anyNeg = 1'b1;
            end else begin
                masked[i*DT_WIDTH +: DT_WIDTH] = req_dt[i*DT_WIDTH +: DT_WIDTH];
            end
        end
        masked[N_REQ*DT_WIDTH +: DT_WIDTH] = (|req_vld) ? DT_MAX : DT_DEFAULT;
    end

    dt_min_tree #(
        .N      (LANES)
    ) u_min_tree (
        .clk_i  (clk),
        .rst_ni (rstInt_n),
        .dt_i   (masked),
        .min_o  (treeMin)
    );

    always_comb begin
        sum     = {1'b0, emuTime_q} + {{(TIME_WIDTH+1-DT_WIDTH){1'b0}}, dt_q};
        emuNext = emuTime_q;
        if (dtVld_q) emuNext = sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
    end

`ifdef EMU_DT_TIME_LIMIT_EN
    logic [TIME_WIDTH-1:0] remain;
    logic                  done_q;

    // Clipping looks at the time after the grant currently on the output has been added.
    always_comb begin
        remain  = (emuNext >= time_limit) ? '0 : time_limit - emuNext;
        grant   = (remain < TIME_WIDTH'(treeMin)) ? dt_t'(remain[DT_WIDTH-1:0]) : treeMin;
        atLimit = (emuNext == time_limit);
    end

    assign done = done_q;
`else
    always_comb begin
        grant   = treeMin;
        atLimit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q   <= INIT;
            dt_q      <= '0;
            dtVld_q   <= 1'b0;
            emuTime_q <= '0;
            negErr_q  <= 1'b0;
`ifdef EMU_DT_TIME_LIMIT_EN
            done_q    <= 1'b0;
`endif
        end else begin
            emuTime_q <= emuNext;
            if (anyNeg) negErr_q <= 1'b1;
            case (state_q)
                INIT: begin
                    state_q <= RUN;
                    dt_q    <= '0;
                    dtVld_q <= 1'b0;
                end
                RUN, HOLD: begin
                    if (atLimit && state_q == RUN) begin
                        state_q <= DONE;
                        dt_q    <= '0;
                        dtVld_q <= 1'b0;
`ifdef EMU_DT_TIME_LIMIT_EN
                        done_q  <= 1'b1;
`endif
                    end else if (stall) begin
                        state_q <= HOLD;
                        dt_q    <= '0;
                        dtVld_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        dt_q    <= grant;
                        dtVld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= DONE;
                    dt_q    <= '0;
                    dtVld_q <= 1'b0;
                end
            endcase
        end
    end

    assign dt       = dt_q;
    assign dt_vld   = dtVld_q;
    assign emu_time = emuTime_q;
    assign neg_err  = negErr_q;

endmodule

// File: tb/tb_emu_dt_arbiter.sv
// Randomised scoreboard bench for emu_dt_arbiter (28-bit time so saturation is reachable).
// Builds with or without EMU_DT_TIME_LIMIT_EN.
module tb_emu_dt_arbiter;

    localparam int     N     = 4;
    localparam int     W     = 27;
    localparam int     TW    = 28;
    localparam int     DEF   = 70369;
    localparam int     DTMAX = (1 << 26) - 1;
    localparam int     NEVER = 1 << 30;
    localparam longint TMAX  = (longint'(1) << TW) - 1;

    typedef struct {
        int tgt;
        int dt;
    } exp_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [N*W-1:0] req_dt = '0;
    logic [N-1:0]  req_vld = '0;
    logic          stall   = 1'b0;
    logic [W-1:0]  dt;
    logic          dt_vld;
    logic [TW-1:0] emu_time;
    logic          neg_err;
`ifdef EMU_DT_TIME_LIMIT_EN
    logic [TW-1:0] time_limit = '1;
    logic          done;
    longint        limit = TMAX;
`endif

    int     cyc;
    int     checks   = 0;
    int     fails    = 0;
    int     prevMin  = DEF;
    int     firstNeg = NEVER;
    longint expTime  = 0;
    bit     doneModel = 1'b0;
    bit     monOn    = 1'b0;
    exp_t   q[$];

    emu_dt_arbiter #(
        .N_REQ      (N),
        .TIME_WIDTH (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_dt     (req_dt),
        .req_vld    (req_vld),
        .stall      (stall),
`ifdef EMU_DT_TIME_LIMIT_EN
        .time_limit (time_limit),
        .done       (done),
`endif
        .dt         (dt),
        .dt_vld     (dt_vld),
        .emu_time   (emu_time),
        .neg_err    (neg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Minimum of the valid requests with negatives counted as zero; default when none valid.
    function automatic int refMin(input int r0, input int r1, input int r2, input int r3,
                                  input logic [3:0] v);
        int vals[4];
        int m;
        bit any;
        vals = '{r0, r1, r2, r3};
        m    = DEF;
        any  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                int x;
                x = (vals[i] < 0) ? 0 : vals[i];
                if (!any || x < m) m = x;
                any = 1'b1;
            end
        end
        return m;
    endfunction

    // Drives one cycle and books the grant expected on the following cycle.
    task automatic applyStimulus(input int r0, input int r1, input int r2, input int r3,
                                 input logic [3:0] v, input logic s);
        exp_t e;
        int   m;
        @(posedge clk);
        #1;
        req_dt  = {27'(r3), 27'(r2), 27'(r1), 27'(r0)};
        req_vld = v;
        stall   = s;
        m = refMin(r0, r1, r2, r3, v);
        if (firstNeg == NEVER && ((v[0] && r0 < 0) || (v[1] && r1 < 0) ||
                                  (v[2] && r2 < 0) || (v[3] && r3 < 0)))
            firstNeg = cyc;
        if (cyc >= 3) begin
            e.tgt = cyc + 1;
            e.dt  = s ? 0 : prevMin;
            q.push_back(e);
        end
        prevMin = m;
    endtask

    task automatic doReset(input longint lim);
        monOn  = 1'b0;
        rst_n  = 1'b0;
        q.delete();
        firstNeg = NEVER;
        prevMin  = DEF;
`ifdef EMU_DT_TIME_LIMIT_EN
        limit      = lim;
        time_limit = TW'(lim);
`else
        if (lim < 0) $display("[TB] negative limit ignored");
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        monOn = 1'b1;
    endtask

    // Monitor: compares every cycle against the model; pops a booked grant when one is due.
    always @(negedge clk) begin
        if (!monOn) begin
            expTime   = 0;
            doneModel = 1'b0;
        end else begin
            exp_t e;
            int   g;
            checkOutput("neg_err", neg_err, 64'(firstNeg < cyc));
            checkOutput("emu_time", emu_time, expTime);
            if (!doneModel && q.size() > 0 && q[0].tgt == cyc) begin
                e = q.pop_front();
                g = e.dt;
`ifdef EMU_DT_TIME_LIMIT_EN
                if (expTime == limit)                 doneModel = 1'b1;
                else if (limit - expTime < longint'(g)) g = int'(limit - expTime);
`endif
                if (!doneModel) begin
                    checkOutput("dt_vld", dt_vld, 1);
                    checkOutput("dt", dt, g);
                    expTime = (expTime + g > TMAX) ? TMAX : expTime + g;
                end else begin
                    checkOutput("dt_vld_done", dt_vld, 0);
                end
            end else begin
                while (q.size() > 0 && q[0].tgt <= cyc) void'(q.pop_front());
                checkOutput("dt_vld_idle", dt_vld, 0);
            end
`ifdef EMU_DT_TIME_LIMIT_EN
            checkOutput("done", done, doneModel);
`endif
        end
    end

    initial begin
        doReset(TMAX);

        // Minimum of four valid requests.
        repeat (6) applyStimulus(70369, 35184, 140737, 7037, 4'hF, 1'b0);
        // Nothing valid, then a single valid requester.
        repeat (4) applyStimulus(70369, 35184, 140737, 7037, 4'h0, 1'b0);
        repeat (4) applyStimulus(0, 0, 35184, 0, 4'b0100, 1'b0);
        // Three-cycle stall during a steady stream.
        repeat (4) applyStimulus(70369, 35184, 140737, 7037, 4'hF, 1'b0);
        repeat (3) applyStimulus(70369, 35184, 140737, 7037, 4'hF, 1'b1);
        repeat (4) applyStimulus(70369, 35184, 140737, 7037, 4'hF, 1'b0);
        // A zero request is a legal zero step.
        repeat (3) applyStimulus(0, 500, 600, 700, 4'hF, 1'b0);

        repeat (300) begin
            applyStimulus(int'($urandom_range(0, 200000)), int'($urandom_range(0, 200000)),
                          int'($urandom_range(0, 200000)), int'($urandom_range(0, 200000)),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
        end

        // Negative request sets a sticky error.
        repeat (3) applyStimulus(70369, -10, 70369, 70369, 4'hF, 1'b0);
        repeat (4) applyStimulus(70369, 100, 70369, 70369, 4'hF, 1'b0);

        // Largest requests drive the accumulator into saturation.
        repeat (12) applyStimulus(DTMAX, DTMAX, DTMAX, DTMAX, 4'hF, 1'b0);
        checkOutput("saturated", emu_time, TMAX);
        repeat (2) applyStimulus(DTMAX, DTMAX, DTMAX, DTMAX, 4'hF, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(5000, 6000, 7000, 8000, 4'hF, 1'b0);
        monOn = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_dt", dt, 0);
        checkOutput("rst_dt_vld", dt_vld, 0);
        checkOutput("rst_emu_time", emu_time, 0);
        checkOutput("rst_neg_err", neg_err, 0);
`ifdef EMU_DT_TIME_LIMIT_EN
        checkOutput("rst_done", done, 0);
        doReset(100000);
        repeat (10) applyStimulus(70369, 70369, 70369, 70369, 4'hF, 1'b0);
        checkOutput("limit_time", emu_time, 100000);
        checkOutput("limit_done", done, 1);
`else
        doReset(TMAX);
        repeat (8) applyStimulus(5000, 4000, 9000, 3000, 4'hF, 1'b0);
`endif
        repeat (3) applyStimulus(DEF, DEF, DEF, DEF, 4'hF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
